// File: rtl/dmem_responder.sv
// Word-addressed data memory responder for the M-stage load/store port: byte-lane stores,
// extending loads, fixed access latency and a pipeline stall. Define DMEM_STATS_EN for access counters.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] ld_count,
  output logic [31:0] st_count,
  output logic [31:0] err_count
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic             r_we;
  logic [2:0]       r_size;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_off;
  logic [31:0]      r_wdata;

  logic [31:0] mem [DEPTH];

  logic             accept, chk_err, busy, complete, mem_we;
  logic             a_we;
  logic [2:0]       a_size;
  logic [IDX_W-1:0] a_idx;
  logic [1:0]       a_off;
  logic [31:0]      a_wdata;
  logic [3:0]       be;
  logic [31:0]      lane_data, rd_word, ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign busy      = (state == BUSY);
  assign req_ready = !busy;
  assign stall     = busy;
  assign resp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // Request checks act on the live request; they only matter on the accept edge.
  always_comb begin
    logic size_ok, misaligned, out_of_range;
    size_ok = req_we ? (req_size inside {3'b000, 3'b001, 3'b010})
                     : (req_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    chk_err = !size_ok || misaligned || out_of_range;
  end

  // The access completes either on the accept edge (LATENCY=1) or from the held copy in BUSY.
  assign a_we    = busy ? r_we    : req_we;
  assign a_size  = busy ? r_size  : req_size;
  assign a_idx   = busy ? r_idx   : req_addr[IDX_W+1:2];
  assign a_off   = busy ? r_off   : req_addr[1:0];
  assign a_wdata = busy ? r_wdata : req_wdata;

  assign complete = busy ? (cnt == 4'd1) : (accept && !chk_err && (LATENCY == 1));
  assign mem_we   = reset && complete && a_we;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      default: begin
        state_nxt = IDLE;
        if (accept) begin
          if (chk_err || (LATENCY == 1)) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
    endcase
  end

  always_comb begin
    be        = 4'b1111;
    lane_data = a_wdata;
    case (a_size[1:0])
      2'b00: begin
        be        = 4'b0001 << a_off;
        lane_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be        = a_off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{a_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_word = mem[a_idx];
  assign ld_byte = rd_word[{a_off, 3'b000} +: 8];
  assign ld_half = a_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (a_size)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // NOTE: the storage array has no reset; clearing it would turn RAM into a flop bank.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[a_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_idx      <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      resp_err   <= accept && chk_err;
      resp_rdata <= (complete && !a_we) ? ld_data : '0;
      if (accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_idx   <= req_addr[IDX_W+1:2];
        r_off   <= req_addr[1:0];
        r_wdata <= req_wdata;
      end
    end
  end

`ifdef DMEM_STATS_EN
  // Counters step on the edge that enters RESP, so they are current during the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_count  <= '0;
      st_count  <= '0;
      err_count <= '0;
    end else if (accept && chk_err) begin
      err_count <= err_count + 32'd1;
    end else if (complete) begin
      if (a_we) st_count <= st_count + 32'd1;
      else      ld_count <= ld_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's M-stage data access (the DCache_WE / ST_Size / LD_Size consumer).
- Accepts one load or store request at a time into an internal word-addressed store with configurable access latency.
- Applies byte-lane masking on stores and sign/zero extension on loads, and returns a one-cycle response.
- Drives a stall back to the pipeline while an access is in flight.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal store; addressed by req_addr[31:2].
- LATENCY, 2, cycles from accept to response for in-range aligned accesses; legal range 1..15.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  3  funct3 of the memory instruction (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid; request was misaligned, out of range or had an illegal size.
- stall  output  1  high while state is BUSY.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE, latency counter to 0.
  - resp_valid=0, resp_err=0, resp_rdata=0, stall=0, req_ready=1.
  - Memory contents are not cleared.
- States: IDLE, BUSY, RESP.
- req_ready is 1 in IDLE and RESP, and 0 in BUSY. A request is accepted on a rising edge where req_valid & req_ready.
- Checks are evaluated combinationally on accept:
  - illegal size: store with size not in {000,001,010}; load with size not in {000,001,010,100,101}.
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - out of range: addr[31:2] >= DEPTH.
  - Any failed check means error.
- Error accept: go directly to RESP. No memory access, no write. Next cycle resp_valid=1, resp_err=1, resp_rdata=0. This is independent of LATENCY.
- Good accept:
  - LATENCY=1: go to RESP.
  - LATENCY>1: go to BUSY, counter loaded with LATENCY-1, decrement each cycle; BUSY goes to RESP on the edge where the counter reaches 0.
  - Request fields are registered at accept and held until completion.
- Completion edge (the edge entering RESP for a good request):
  - A store writes its enabled lanes. SB writes one lane selected by addr[1:0]; SH writes lanes {1,0} or {3,2} selected by addr[1]; SW writes all four.
  - A load reads the word, selects the byte or half by address, sign-extends (LB/LH) or zero-extends (LBU/LHU), and registers the result to resp_rdata.
- RESP lasts exactly one cycle: resp_valid=1, resp_err=0; resp_rdata is load data, or 0 for stores.
  - A new request may be accepted in the RESP cycle (back-to-back); the next state follows the accept rules above.
  - With no request, RESP goes to IDLE.
- Outside RESP: resp_valid=0, resp_err=0, resp_rdata=0.
- Total latency, accept edge to resp_valid high: LATENCY cycles for a good request, 1 cycle for an error.
- Read-after-write: a load accepted in the RESP cycle of a store to the same word observes the stored value.
- Reset asserted in BUSY: the access is abandoned, no write occurs, and no response is produced.
- req_valid while BUSY is ignored. The requester must hold the request; stall is high.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs ld_count[31:0], st_count[31:0] and err_count[31:0].
  - Each increments by 1 in the RESP cycle of a good load, a good store, or an error respectively.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LATENCY=2, SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10:
  - store: stall=1 for 1 cycle, then resp_valid=1 with resp_rdata=0.
  - load: resp_rdata=0xDEADBEEF, resp_err=0.
- SB addr=0x13 wdata=0x80, then LB 0x13 and LBU 0x13 -> resp_rdata 0xFFFFFF80, then 0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH addr=0x22 wdata=0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> upper half 0x8001, lower half unchanged.
- Errors, each giving resp_valid=1, resp_err=1, resp_rdata=0 one cycle after accept with no write:
  - LW 0x11.
  - SH 0x21.
  - size=011 load.
  - addr=DEPTH*4.
  - A following LW of the targeted word returns the old data.
- Back-to-back: SW 0x40=0x12345678 and LW 0x40 presented on consecutive accepts (second accepted in the RESP cycle) -> load returns 0x12345678; req_ready=0 throughout BUSY.
- Drop reset to 0 during the BUSY cycle of SW 0x50=0xFFFFFFFF:
  - all outputs 0 immediately; req_ready=1 after release.
  - LW 0x50 returns the prior value.
  - With DMEM_STATS_EN defined, counters read 0.
